// File: rtl/gcc_poll_sequencer.sv
// Host-side GameCube controller poll sequencer: sends 0x4003_0R, then decodes the 64-bit reply by low-time.
// Optional macro GCC_AUTO_POLL_EN replaces the external start with a free-running POLL_PERIOD_US timer.
module gcc_poll_sequencer #(
    parameter int US_CYCLES       = 48,
    parameter int RESP_TIMEOUT_US = 100,
    parameter int BIT_TIMEOUT_US  = 8,
    parameter int POLL_PERIOD_US  = 1000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic        rumble,
    input  logic        line_in,
    output logic        line_oe,
    output logic        busy,
    output logic [63:0] rx_data,
    output logic        rx_valid,
    output logic        timeout_err
);

    // Handshake: start is a single-cycle request honoured only while the FSM sits in IDLE;
    // rx_valid / timeout_err are single-cycle strobes with no back-pressure.

    localparam int ONE_US_CYC   = US_CYCLES;
    localparam int THREE_US_CYC = 3 * US_CYCLES;
    localparam int SLOT_CYC     = 4 * US_CYCLES;
    localparam int THRESH_CYC   = 2 * US_CYCLES;
    localparam int RESP_CYC     = RESP_TIMEOUT_US * US_CYCLES;
    localparam int BIT_CYC      = BIT_TIMEOUT_US * US_CYCLES;
    localparam int CNT_MAX_A    = (RESP_CYC > BIT_CYC) ? RESP_CYC : BIT_CYC;
    localparam int CNT_MAX      = (CNT_MAX_A > SLOT_CYC) ? CNT_MAX_A : SLOT_CYC;
    localparam int CNT_W        = $clog2(CNT_MAX + 1);

    localparam logic [3:0] S_IDLE        = 4'd0;
    localparam logic [3:0] S_TX_LOW      = 4'd1;
    localparam logic [3:0] S_TX_HIGH     = 4'd2;
    localparam logic [3:0] S_TX_STOP     = 4'd3;
    localparam logic [3:0] S_RX_WAIT     = 4'd4;
    localparam logic [3:0] S_RX_LOW      = 4'd5;
    localparam logic [3:0] S_RX_HIGH     = 4'd6;
    localparam logic [3:0] S_RX_STOP     = 4'd7;
    localparam logic [3:0] S_RX_STOP_LOW = 4'd8;
    localparam logic [3:0] S_DONE        = 4'd9;
    localparam logic [3:0] S_ERR         = 4'd10;

    logic             sync1_q, sync2_q, prev_q;
    logic [3:0]       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d, cnt_inc;
    logic [23:0]      cmd_q, cmd_d;
    logic [4:0]       tx_bits_q, tx_bits_d;
    logic [63:0]      rx_sh_q, rx_sh_d;
    logic [5:0]       rx_bits_q, rx_bits_d;
    logic [63:0]      rx_data_q, rx_data_d;
    logic             fall, rise, start_int;
    logic [CNT_W-1:0] tx_low_last, tx_high_last;

`ifdef GCC_AUTO_POLL_EN
    localparam int POLL_CYC = POLL_PERIOD_US * US_CYCLES;
    localparam int POLL_W   = $clog2(POLL_CYC);

    logic [POLL_W-1:0] period_q;
    logic              start_unused;

    // Free-running: a tick that lands while busy is simply lost, no resync.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            period_q <= '0;
        end else if (period_q == POLL_W'(POLL_CYC - 1)) begin
            period_q <= '0;
        end else begin
            period_q <= period_q + 1'b1;
        end
    end

    assign start_int    = (period_q == POLL_W'(POLL_CYC - 1));
    assign start_unused = start;
`else
    localparam int POLL_CYC_unused = POLL_PERIOD_US * US_CYCLES;

    assign start_int = start;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q <= 1'b1;
            sync2_q <= 1'b1;
            prev_q  <= 1'b1;
        end else begin
            sync1_q <= line_in;
            sync2_q <= sync1_q;
            prev_q  <= sync2_q;
        end
    end

    assign fall = prev_q & ~sync2_q;
    assign rise = ~prev_q & sync2_q;

    assign cnt_inc      = (cnt_q == {CNT_W{1'b1}}) ? cnt_q : cnt_q + 1'b1;
    assign tx_low_last  = cmd_q[23] ? CNT_W'(ONE_US_CYC - 1) : CNT_W'(THREE_US_CYC - 1);
    assign tx_high_last = cmd_q[23] ? CNT_W'(THREE_US_CYC - 1) : CNT_W'(ONE_US_CYC - 1);

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_inc;
        cmd_d     = cmd_q;
        tx_bits_d = tx_bits_q;
        rx_sh_d   = rx_sh_q;
        rx_bits_d = rx_bits_q;
        rx_data_d = rx_data_q;
        case (state_q)
            S_IDLE: begin
                cnt_d = '0;
                if (start_int) begin
                    state_d   = S_TX_LOW;
                    cmd_d     = {8'h40, 8'h03, 7'b0, rumble};
                    tx_bits_d = '0;
                    rx_bits_d = '0;
                end
            end
            S_TX_LOW: begin
                if (cnt_q == tx_low_last) begin
                    state_d = S_TX_HIGH;
                    cnt_d   = '0;
                end
            end
            S_TX_HIGH: begin
                if (cnt_q == tx_high_last) begin
                    cnt_d = '0;
                    cmd_d = {cmd_q[22:0], 1'b0};
                    if (tx_bits_q == 5'd23) begin
                        state_d = S_TX_STOP;
                    end else begin
                        tx_bits_d = tx_bits_q + 5'd1;
                        state_d   = S_TX_LOW;
                    end
                end
            end
            S_TX_STOP: begin
                if (cnt_q == CNT_W'(ONE_US_CYC - 1)) begin
                    state_d = S_RX_WAIT;
                    cnt_d   = '0;
                end
            end
            S_RX_WAIT: begin
                if (fall) begin
                    state_d = S_RX_LOW;
                    cnt_d   = CNT_W'(1);
                end else if (cnt_q >= CNT_W'(RESP_CYC - 1)) begin
                    state_d = S_ERR;
                end
            end
            // The falling-edge cycle counts as the first low cycle, so cnt_q equals the low width at the rise.
            S_RX_LOW: begin
                if (rise) begin
                    rx_sh_d = {rx_sh_q[62:0], (cnt_q <= CNT_W'(THRESH_CYC))};
                    cnt_d   = CNT_W'(1);
                    if (rx_bits_q == 6'd63) begin
                        state_d = S_RX_STOP;
                    end else begin
                        rx_bits_d = rx_bits_q + 6'd1;
                        state_d   = S_RX_HIGH;
                    end
                end else if (cnt_q >= CNT_W'(BIT_CYC)) begin
                    state_d = S_ERR;
                end
            end
            S_RX_HIGH: begin
                if (fall) begin
                    state_d = S_RX_LOW;
                    cnt_d   = CNT_W'(1);
                end else if (cnt_q >= CNT_W'(BIT_CYC)) begin
                    state_d = S_ERR;
                end
            end
            S_RX_STOP: begin
                if (fall) begin
                    state_d = S_RX_STOP_LOW;
                    cnt_d   = CNT_W'(1);
                end else if (cnt_q >= CNT_W'(BIT_CYC)) begin
                    state_d = S_ERR;
                end
            end
            S_RX_STOP_LOW: begin
                if (rise) begin
                    state_d   = S_DONE;
                    rx_data_d = rx_sh_q;
                end else if (cnt_q >= CNT_W'(BIT_CYC)) begin
                    state_d = S_ERR;
                end
            end
            S_DONE, S_ERR: begin
                state_d = S_IDLE;
                cnt_d   = '0;
            end
            default: begin
                state_d = S_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            cmd_q     <= '0;
            tx_bits_q <= '0;
            rx_sh_q   <= '0;
            rx_bits_q <= '0;
            rx_data_q <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            cmd_q     <= cmd_d;
            tx_bits_q <= tx_bits_d;
            rx_sh_q   <= rx_sh_d;
            rx_bits_q <= rx_bits_d;
            rx_data_q <= rx_data_d;
        end
    end

    // Decoded straight from state so an asynchronous reset releases the line at once.
    assign line_oe     = (state_q == S_TX_LOW) || (state_q == S_TX_STOP);
    assign busy        = (state_q != S_IDLE) && (state_q != S_DONE) && (state_q != S_ERR);
    assign rx_valid    = (state_q == S_DONE);
    assign timeout_err = (state_q == S_ERR);
    assign rx_data     = rx_data_q;

endmodule

// File: tb/tb_gcc_poll_sequencer.sv
// Directed bench for gcc_poll_sequencer: measures the host waveform and plays a controller model on the line.
module tb_gcc_poll_sequencer;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic        rumble;
    logic        line_in;
    logic        line_oe;
    logic        busy;
    logic [63:0] rx_data;
    logic        rx_valid;
    logic        timeout_err;
    logic        ctrl_low;

    int checks;
    int errors;
    int valid_cnt;
    int err_cnt;

    localparam logic [63:0] GOOD_DATA = 64'h0080808080800000;
    localparam logic [63:0] THR_DATA  = 64'hA5C30F961E2D7B48;

    gcc_poll_sequencer dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .rumble      (rumble),
        .line_in     (line_in),
        .line_oe     (line_oe),
        .busy        (busy),
        .rx_data     (rx_data),
        .rx_valid    (rx_valid),
        .timeout_err (timeout_err)
    );

    // Open-drain line with an external pull-up.
    assign line_in = ~(line_oe | ctrl_low);

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(negedge clk) begin
        if (rx_valid === 1'b1) valid_cnt++;
        if (timeout_err === 1'b1) err_cnt++;
    end

    initial begin
        #1500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic pulse_start(input logic rmb);
        @(negedge clk);
        start  = 1'b1;
        rumble = rmb;
        @(negedge clk);
        start  = 1'b0;
    endtask

    task automatic run_len(input logic level, output int n);
        n = 0;
        while (line_oe === level && n < 400) begin
            n++;
            @(negedge clk);
        end
    endtask

    task automatic capture_tx(output logic [23:0] word, output int first_low, output int first_high,
                              output int last_low, output int stop_low, output int total,
                              output int bad_slots);
        int lo, hi, w;
        w = 0;
        while (line_oe !== 1'b1 && w < 50) begin
            @(negedge clk);
            w++;
        end
        word = '0; total = 0; bad_slots = 0;
        first_low = 0; first_high = 0; last_low = 0;
        for (int i = 0; i < 24; i++) begin
            run_len(1'b1, lo);
            run_len(1'b0, hi);
            word = {word[22:0], (lo == 48)};
            if ((lo + hi) != 192 || (lo != 48 && lo != 144)) bad_slots++;
            if (i == 0) begin
                first_low  = lo;
                first_high = hi;
            end
            if (i == 23) last_low = lo;
            total += lo + hi;
        end
        run_len(1'b1, stop_low);
        total += stop_low;
    endtask

    task automatic send_bit(input int low_len, input int high_len);
        ctrl_low = 1'b1;
        repeat (low_len) @(negedge clk);
        ctrl_low = 1'b0;
        repeat (high_len) @(negedge clk);
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        repeat (5) @(negedge clk);
        checks++; if (line_oe !== 1'b0) begin errors++; $display("FAIL reset_line_oe got %b want 0", line_oe); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", busy); end
        checks++; if (rx_data !== 64'd0) begin errors++; $display("FAIL reset_rx_data got %h want 0", rx_data); end
        checks++; if (rx_valid !== 1'b0) begin errors++; $display("FAIL reset_rx_valid got %b want 0", rx_valid); end
        checks++; if (timeout_err !== 1'b0) begin errors++; $display("FAIL reset_timeout_err got %b want 0", timeout_err); end
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
    endtask

    task automatic test_cmd_encoding(input logic rmb);
        logic [23:0] word;
        int fl, fh, ll, sl, tot, bad;
        logic [23:0] exp_word;
        exp_word = {8'h40, 8'h03, 7'b0, rmb};
        pulse_start(rmb);
        capture_tx(word, fl, fh, ll, sl, tot, bad);
        checks++; if (fl !== 144) begin errors++; $display("FAIL cmd_first_low got %0d want 144", fl); end
        checks++; if (fh !== 48) begin errors++; $display("FAIL cmd_first_high got %0d want 48", fh); end
        checks++; if (word !== exp_word) begin errors++; $display("FAIL cmd_word got %h want %h", word, exp_word); end
        checks++; if (bad !== 0) begin errors++; $display("FAIL cmd_slot_shape got %0d bad slots want 0", bad); end
        checks++; if (ll !== (rmb ? 48 : 144)) begin errors++; $display("FAIL cmd_last_low got %0d want %0d", ll, rmb ? 48 : 144); end
        checks++; if (sl !== 48) begin errors++; $display("FAIL cmd_stop_low got %0d want 48", sl); end
        checks++; if (tot !== 4656) begin errors++; $display("FAIL cmd_total got %0d want 4656", tot); end
    endtask

    // Called right after the host stop bit, with the line just released.
    task automatic test_good_reply;
        int v0, e0, n;
        v0 = valid_cnt; e0 = err_cnt;
        repeat (480) @(negedge clk);
        for (int i = 63; i >= 0; i--) begin
            if (GOOD_DATA[i]) send_bit(48, 144);
            else send_bit(144, 48);
        end
        ctrl_low = 1'b1;
        repeat (48) @(negedge clk);
        ctrl_low = 1'b0;
        n = 0;
        while (rx_valid !== 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        checks++; if (rx_valid !== 1'b1) begin errors++; $display("FAIL good_rx_valid got %b want 1", rx_valid); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL good_busy_with_valid got %b want 0", busy); end
        checks++; if (rx_data !== GOOD_DATA) begin errors++; $display("FAIL good_rx_data got %h want %h", rx_data, GOOD_DATA); end
        repeat (5) @(negedge clk);
        checks++; if ((valid_cnt - v0) !== 1) begin errors++; $display("FAIL good_valid_pulses got %0d want 1", valid_cnt - v0); end
        checks++; if ((err_cnt - e0) !== 0) begin errors++; $display("FAIL good_err_pulses got %0d want 0", err_cnt - e0); end
    endtask

    task automatic test_no_reply;
        int v0, e0, n;
        v0 = valid_cnt; e0 = err_cnt;
        n = 0;
        while (timeout_err !== 1'b1 && n < 6000) begin
            @(negedge clk);
            n++;
        end
        checks++; if (n !== 4800) begin errors++; $display("FAIL noreply_latency got %0d want 4800", n); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL noreply_busy got %b want 0", busy); end
        checks++; if (rx_data !== GOOD_DATA) begin errors++; $display("FAIL noreply_rx_data got %h want %h", rx_data, GOOD_DATA); end
        repeat (5) @(negedge clk);
        checks++; if ((valid_cnt - v0) !== 0) begin errors++; $display("FAIL noreply_valid_pulses got %0d want 0", valid_cnt - v0); end
        checks++; if ((err_cnt - e0) !== 1) begin errors++; $display("FAIL noreply_err_pulses got %0d want 1", err_cnt - e0); end
    endtask

    // Lows of 96 cycles must decode as 1 and 97 cycles as 0.
    task automatic test_bit_threshold;
        logic [23:0] word;
        int fl, fh, ll, sl, tot, bad, n;
        pulse_start(1'b0);
        capture_tx(word, fl, fh, ll, sl, tot, bad);
        repeat (480) @(negedge clk);
        for (int i = 63; i >= 0; i--) begin
            if (THR_DATA[i]) send_bit(96, 96);
            else send_bit(97, 96);
        end
        ctrl_low = 1'b1;
        repeat (48) @(negedge clk);
        ctrl_low = 1'b0;
        n = 0;
        while (rx_valid !== 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        checks++; if (rx_valid !== 1'b1) begin errors++; $display("FAIL thresh_rx_valid got %b want 1", rx_valid); end
        checks++; if (rx_data !== THR_DATA) begin errors++; $display("FAIL thresh_rx_data got %h want %h", rx_data, THR_DATA); end
        repeat (5) @(negedge clk);
    endtask

    task automatic test_truncated_busy_drop;
        logic [23:0] word;
        int fl, fh, ll, sl, tot, bad, n, v0, e0, oe_seen, busy_seen;
        pulse_start(1'b0);
        capture_tx(word, fl, fh, ll, sl, tot, bad);
        v0 = valid_cnt; e0 = err_cnt;
        repeat (480) @(negedge clk);
        for (int i = 63; i >= 24; i--) begin
            ctrl_low = 1'b1;
            repeat (GOOD_DATA[i] ? 48 : 144) @(negedge clk);
            ctrl_low = 1'b0;
            if (i == 24) break;
            if (i == 44) begin
                checks++; if (busy !== 1'b1) begin errors++; $display("FAIL drop_busy_during_rx got %b want 1", busy); end
                start = 1'b1;
                @(negedge clk);
                start = 1'b0;
                repeat (GOOD_DATA[i] ? 143 : 47) @(negedge clk);
            end else begin
                repeat (GOOD_DATA[i] ? 144 : 48) @(negedge clk);
            end
        end
        n = 0;
        while (timeout_err !== 1'b1 && n < 1000) begin
            @(negedge clk);
            n++;
        end
        checks++; if (n < 384 || n > 392) begin errors++; $display("FAIL trunc_latency got %0d want 384..392", n); end
        checks++; if (rx_data !== THR_DATA) begin errors++; $display("FAIL trunc_rx_data got %h want %h", rx_data, THR_DATA); end
        oe_seen = 0; busy_seen = 0;
        repeat (300) begin
            @(negedge clk);
            if (line_oe !== 1'b0) oe_seen++;
            if (busy !== 1'b0) busy_seen++;
        end
        checks++; if (oe_seen !== 0) begin errors++; $display("FAIL drop_no_second_tx got %0d driven cycles want 0", oe_seen); end
        checks++; if (busy_seen !== 0) begin errors++; $display("FAIL drop_idle_busy got %0d busy cycles want 0", busy_seen); end
        checks++; if ((valid_cnt - v0) !== 0) begin errors++; $display("FAIL trunc_valid_pulses got %0d want 0", valid_cnt - v0); end
        checks++; if ((err_cnt - e0) !== 1) begin errors++; $display("FAIL trunc_err_pulses got %0d want 1", err_cnt - e0); end
    endtask

    task automatic test_reset_mid_tx;
        int oe_seen;
        pulse_start(1'b0);
        repeat (20) @(negedge clk);
        checks++; if (line_oe !== 1'b1) begin errors++; $display("FAIL midrst_driving got %b want 1", line_oe); end
        #2 rst_n = 1'b0;
        #1;
        checks++; if (line_oe !== 1'b0) begin errors++; $display("FAIL midrst_line_oe got %b want 0", line_oe); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL midrst_busy got %b want 0", busy); end
        repeat (5) @(negedge clk);
        checks++; if (rx_data !== 64'd0) begin errors++; $display("FAIL midrst_rx_data got %h want 0", rx_data); end
        rst_n = 1'b1;
        oe_seen = 0;
        repeat (50) begin
            @(negedge clk);
            if (line_oe !== 1'b0) oe_seen++;
        end
        checks++; if (oe_seen !== 0) begin errors++; $display("FAIL midrst_stays_idle got %0d driven cycles want 0", oe_seen); end
    endtask

    initial begin
        checks    = 0;
        errors    = 0;
        valid_cnt = 0;
        err_cnt   = 0;
        rst_n     = 1'b0;
        start     = 1'b0;
        rumble    = 1'b0;
        ctrl_low  = 1'b0;
        test_reset;
        test_cmd_encoding(1'b0);
        test_good_reply;
        test_cmd_encoding(1'b1);
        test_no_reply;
        test_bit_threshold;
        test_truncated_busy_drop;
        test_reset_mid_tx;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
